// File: rtl/gs_fixed_pkg.sv
// gs_fixed_pkg: shared fixed-point types, saturation helpers and checker state enum.
package gs_fixed_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int FRAC = 16;
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + 2;
    typedef logic signed [DATA_WIDTH-1:0] fixed_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef logic [DATA_WIDTH-1:0] umag_t;
    localparam fixed_t FIX_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam fixed_t FIX_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_FIN} chk_state_e;
    typedef struct packed {
        fixed_t a11;
        fixed_t a12;
        fixed_t a21;
        fixed_t a22;
        fixed_t x1;
        fixed_t x2;
        umag_t  eps;
    } chk_ops_t;
    // Value fits when every bit above the result sign matches it.
    function automatic fixed_t sat_narrow(input acc_t v);
        return (&v[ACC_WIDTH-1:DATA_WIDTH-1] || ~|v[ACC_WIDTH-1:DATA_WIDTH-1])
            ? v[DATA_WIDTH-1:0] : (v[ACC_WIDTH-1] ? FIX_MIN : FIX_MAX);
    endfunction
    function automatic umag_t sat_abs(input fixed_t v);
        return (v == FIX_MIN) ? FIX_MAX : (v[DATA_WIDTH-1] ? -v : v);
    endfunction
endpackage

// File: rtl/gs2x2_residual_checker_if.sv
// gs2x2_residual_checker_if: operand/request and result bundle of the residual checker.
interface gs2x2_residual_checker_if;
    import gs_fixed_pkg::*;
    logic   start;
    fixed_t a11, a12, a21, a22, b1, b2, x1, x2;
    umag_t  epsilon;
    fixed_t r1, r2;
    umag_t  max_abs_r;
    logic   within_tol, busy, done;
    modport master(
        output start, a11, a12, a21, a22, b1, b2, x1, x2, epsilon,
        input  r1, r2, max_abs_r, within_tol, busy, done
    );
    modport slave(
        input  start, a11, a12, a21, a22, b1, b2, x1, x2, epsilon,
        output r1, r2, max_abs_r, within_tol, busy, done
    );
endinterface

// File: rtl/gs_fixed_mac.sv
// gs_fixed_mac: acc_next = acc - ((a * x) >>> FRAC), full-precision signed datapath.
module gs_fixed_mac
    import gs_fixed_pkg::*;
(
    input  acc_t   acc,
    input  fixed_t a,
    input  fixed_t x,
    output acc_t   acc_next
);
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [2*DATA_WIDTH-1:0] prod_sh;
    assign prod = a * x;
    assign prod_sh = prod >>> FRAC;
    assign acc_next = acc - {{(ACC_WIDTH-2*DATA_WIDTH){prod_sh[2*DATA_WIDTH-1]}}, prod_sh};
endmodule

// File: rtl/gs2x2_residual_checker.sv
// gs2x2_residual_checker: r = b - A*x with one shared multiplier, 5-cycle latency, tolerance check.
module gs2x2_residual_checker
    import gs_fixed_pkg::*;
(
    input logic clk,
    input logic rst,
    gs2x2_residual_checker_if.slave bus
);
    chk_state_e state_q, state_d;
    logic [1:0] step_q, step_d;
    chk_ops_t   op_q, op_d;
    acc_t       acc1_q, acc1_d, acc2_q, acc2_d;
    fixed_t     r1_q, r1_d, r2_q, r2_d;
    umag_t      max_q, max_d;
    logic       tol_q, tol_d, busy_q, busy_d, done_q, done_d;
    acc_t       mac_acc, mac_out;
    fixed_t     mac_a, mac_x, sr1, sr2;
    umag_t      abs1, abs2;
    // Steps 0,1 update acc1 and steps 2,3 update acc2; odd steps use x2.
    assign mac_acc = step_q[1] ? acc2_q : acc1_q;
    assign mac_a = step_q[1] ? (step_q[0] ? op_q.a22 : op_q.a21) : (step_q[0] ? op_q.a12 : op_q.a11);
    assign mac_x = step_q[0] ? op_q.x2 : op_q.x1;
    assign sr1 = sat_narrow(acc1_q);
    assign sr2 = sat_narrow(acc2_q);
    assign abs1 = sat_abs(sr1);
    assign abs2 = sat_abs(sr2);
    gs_fixed_mac u_mac (
        .acc(mac_acc),
        .a(mac_a),
        .x(mac_x),
        .acc_next(mac_out)
    );
    always_comb begin
        state_d = state_q;
        step_d = step_q;
        op_d = op_q;
        acc1_d = acc1_q;
        acc2_d = acc2_q;
        r1_d = r1_q;
        r2_d = r2_q;
        max_d = max_q;
        tol_d = tol_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                op_d = '{a11: bus.a11, a12: bus.a12, a21: bus.a21, a22: bus.a22,
                         x1: bus.x1, x2: bus.x2, eps: bus.epsilon};
                acc1_d = {{(ACC_WIDTH-DATA_WIDTH){bus.b1[DATA_WIDTH-1]}}, bus.b1};
                acc2_d = {{(ACC_WIDTH-DATA_WIDTH){bus.b2[DATA_WIDTH-1]}}, bus.b2};
                step_d = 2'd0;
                busy_d = 1'b1;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                acc1_d = step_q[1] ? acc1_q : mac_out;
                acc2_d = step_q[1] ? mac_out : acc2_q;
                step_d = step_q + 2'd1;
                state_d = (step_q == 2'd3) ? ST_FIN : ST_MUL;
            end
            ST_FIN: begin
                r1_d = sr1;
                r2_d = sr2;
                max_d = (abs1 > abs2) ? abs1 : abs2;
                tol_d = (abs1 < op_q.eps) && (abs2 < op_q.eps);
                done_d = 1'b1;
                busy_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q <= '0;
            op_q <= '0;
            acc1_q <= '0;
            acc2_q <= '0;
            r1_q <= '0;
            r2_q <= '0;
            max_q <= '0;
            tol_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q <= step_d;
            op_q <= op_d;
            acc1_q <= acc1_d;
            acc2_q <= acc2_d;
            r1_q <= r1_d;
            r2_q <= r2_d;
            max_q <= max_d;
            tol_q <= tol_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign bus.r1 = r1_q;
    assign bus.r2 = r2_q;
    assign bus.max_abs_r = max_q;
    assign bus.within_tol = tol_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_gs2x2_residual_checker.sv
// tb_gs2x2_residual_checker: directed vectors with hand-computed residuals for the 2x2 checker.
module tb_gs2x2_residual_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    gs2x2_residual_checker_if bus();
    gs2x2_residual_checker dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [31:0] a11, a12, a21, a22, b1, b2, x1, x2, eps);
        bus.a11 = a11; bus.a12 = a12; bus.a21 = a21; bus.a22 = a22;
        bus.b1 = b1; bus.b2 = b2; bus.x1 = x1; bus.x2 = x2; bus.epsilon = eps;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20 && cyc == 0; i++) begin
            tick();
            if (bus.done === 1'b1) cyc = i;
        end
    endtask

    task automatic run_check(output int cyc);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(cyc);
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        set_ops(32'h0003_0000, 0, 0, 0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 0, 32'h028F);
        rst = 1'b1;
        tick();
        tick();
        n_checks += 6;
        if (bus.r1 !== 32'h0) begin n_fail++; $display("FAIL reset_r1: got %h want 0", bus.r1); end
        if (bus.r2 !== 32'h0) begin n_fail++; $display("FAIL reset_r2: got %h want 0", bus.r2); end
        if (bus.max_abs_r !== 32'h0) begin n_fail++; $display("FAIL reset_max: got %h want 0", bus.max_abs_r); end
        if (bus.within_tol !== 1'b0) begin n_fail++; $display("FAIL reset_tol: got %b want 0", bus.within_tol); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        bus.start = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    // A=[3,-1;-1,3], b=(4,2), exact solution x=(1.75,1.25)
    task automatic test_exact();
        int nb;
        int cyc;
        set_ops(32'h0003_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0003_0000,
                32'h0004_0000, 32'h0002_0000, 32'h0001_C000, 32'h0001_4000, 32'h028F);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        nb = (bus.busy === 1'b1) ? 1 : 0;
        cyc = 0;
        for (int i = 1; i <= 20 && cyc == 0; i++) begin
            tick();
            if (bus.busy === 1'b1) nb++;
            if (bus.done === 1'b1) cyc = i;
        end
        n_checks += 6;
        if (cyc !== 5) begin n_fail++; $display("FAIL exact_latency: got %0d want 5", cyc); end
        if (nb !== 5) begin n_fail++; $display("FAIL exact_busy_cycles: got %0d want 5", nb); end
        if (bus.r1 !== 32'h0) begin n_fail++; $display("FAIL exact_r1: got %h want 0", bus.r1); end
        if (bus.r2 !== 32'h0) begin n_fail++; $display("FAIL exact_r2: got %h want 0", bus.r2); end
        if (bus.max_abs_r !== 32'h0) begin n_fail++; $display("FAIL exact_max: got %h want 0", bus.max_abs_r); end
        if (bus.within_tol !== 1'b1) begin n_fail++; $display("FAIL exact_tol: got %b want 1", bus.within_tol); end
        tick();
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL exact_done_pulse: got %b want 0", bus.done); end
    endtask

    // 2*0x19999+0x1CCCC = 0x4FFFE -> r1=2; 0x19999+3*0x1CCCC = 0x6FFFD -> r2=3
    task automatic test_quantised();
        int cyc;
        set_ops(32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 32'h0003_0000,
                32'h0005_0000, 32'h0007_0000, 32'h0001_9999, 32'h0001_CCCC, 32'h028F);
        run_check(cyc);
        n_checks += 5;
        if (cyc !== 5) begin n_fail++; $display("FAIL quant_latency: got %0d want 5", cyc); end
        if (bus.r1 !== 32'h2) begin n_fail++; $display("FAIL quant_r1: got %h want 2", bus.r1); end
        if (bus.r2 !== 32'h3) begin n_fail++; $display("FAIL quant_r2: got %h want 3", bus.r2); end
        if (bus.max_abs_r !== 32'h3) begin n_fail++; $display("FAIL quant_max: got %h want 3", bus.max_abs_r); end
        if (bus.within_tol !== 1'b1) begin n_fail++; $display("FAIL quant_tol: got %b want 1", bus.within_tol); end
        tick();
    endtask

    task automatic test_unsolved();
        int cyc;
        set_ops(32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 32'h0003_0000,
                32'h0005_0000, 32'h0007_0000, 0, 0, 32'h028F);
        run_check(cyc);
        n_checks += 4;
        if (bus.r1 !== 32'h0005_0000) begin n_fail++; $display("FAIL unsolved_r1: got %h want 00050000", bus.r1); end
        if (bus.r2 !== 32'h0007_0000) begin n_fail++; $display("FAIL unsolved_r2: got %h want 00070000", bus.r2); end
        if (bus.max_abs_r !== 32'h0007_0000) begin n_fail++; $display("FAIL unsolved_max: got %h want 00070000", bus.max_abs_r); end
        if (bus.within_tol !== 1'b0) begin n_fail++; $display("FAIL unsolved_tol: got %b want 0", bus.within_tol); end
        tick();
    endtask

    task automatic test_saturation();
        int cyc;
        set_ops(32'h7530_0000, 0, 0, 0, 0, 0, 32'h7530_0000, 0, 32'h028F);
        run_check(cyc);
        n_checks += 4;
        if (bus.r1 !== 32'h8000_0000) begin n_fail++; $display("FAIL sat_r1: got %h want 80000000", bus.r1); end
        if (bus.r2 !== 32'h0) begin n_fail++; $display("FAIL sat_r2: got %h want 0", bus.r2); end
        if (bus.max_abs_r !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_max: got %h want 7fffffff", bus.max_abs_r); end
        if (bus.within_tol !== 1'b0) begin n_fail++; $display("FAIL sat_tol: got %b want 0", bus.within_tol); end
        tick();
    endtask

    task automatic test_boundary();
        int cyc;
        set_ops(0, 0, 0, 0, 32'h028F, 0, 0, 0, 32'h028F);
        run_check(cyc);
        n_checks += 2;
        if (bus.max_abs_r !== 32'h028F) begin n_fail++; $display("FAIL bound_eq_max: got %h want 0000028f", bus.max_abs_r); end
        if (bus.within_tol !== 1'b0) begin n_fail++; $display("FAIL bound_eq_tol: got %b want 0", bus.within_tol); end
        tick();
        set_ops(0, 0, 0, 0, 32'h028E, 0, 0, 0, 32'h028F);
        run_check(cyc);
        n_checks++;
        if (bus.within_tol !== 1'b1) begin n_fail++; $display("FAIL bound_below_tol: got %b want 1", bus.within_tol); end
        tick();
        set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_check(cyc);
        n_checks += 2;
        if (bus.r1 !== 32'h0) begin n_fail++; $display("FAIL bound_eps0_r1: got %h want 0", bus.r1); end
        if (bus.within_tol !== 1'b0) begin n_fail++; $display("FAIL bound_eps0_tol: got %b want 0", bus.within_tol); end
        tick();
    endtask

    task automatic test_control();
        int cyc;
        int nd;
        set_ops(32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 32'h0003_0000,
                32'h0005_0000, 32'h0007_0000, 0, 0, 32'h028F);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        set_ops(32'h0003_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0003_0000,
                32'h0004_0000, 32'h0002_0000, 32'h0001_C000, 32'h0001_4000, 32'h7FFF_FFFF);
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(cyc);
        n_checks += 4;
        if (cyc !== 3) begin n_fail++; $display("FAIL ctrl_latency: got %0d want 3 more cycles", cyc); end
        if (bus.r1 !== 32'h0005_0000) begin n_fail++; $display("FAIL ctrl_latched_r1: got %h want 00050000", bus.r1); end
        if (bus.within_tol !== 1'b0) begin n_fail++; $display("FAIL ctrl_latched_tol: got %b want 0", bus.within_tol); end
        tick();
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ctrl_no_retrigger: busy got %b want 0", bus.busy); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks += 4;
        if (bus.r1 !== 32'h0) begin n_fail++; $display("FAIL ctrl_rst_r1: got %h want 0", bus.r1); end
        if (bus.max_abs_r !== 32'h0) begin n_fail++; $display("FAIL ctrl_rst_max: got %h want 0", bus.max_abs_r); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ctrl_rst_busy: got %b want 0", bus.busy); end
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done !== 1'b0) nd++;
        end
        if (nd !== 0) begin n_fail++; $display("FAIL ctrl_rst_no_done: got %0d done cycles want 0", nd); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_checks += 3;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ctrl_restart_busy: got %b want 1", bus.busy); end
        wait_done(cyc);
        if (cyc !== 5) begin n_fail++; $display("FAIL ctrl_restart_latency: got %0d want 5", cyc); end
        if (bus.within_tol !== 1'b1) begin n_fail++; $display("FAIL ctrl_restart_tol: got %b want 1", bus.within_tol); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        set_ops(32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 32'h0003_0000,
                32'h0005_0000, 32'h0007_0000, 0, 0, 32'h028F);
        bus.start = 1'b1;
        tick();
        wait_done(cyc);
        n_checks += 5;
        if (cyc !== 5) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 5", cyc); end
        if (bus.r2 !== 32'h0007_0000) begin n_fail++; $display("FAIL b2b_first_r2: got %h want 00070000", bus.r2); end
        set_ops(32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 32'h0003_0000,
                32'h0005_0000, 32'h0007_0000, 32'h0001_9999, 32'h0001_CCCC, 32'h028F);
        tick();
        bus.start = 1'b0;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_reaccept_busy: got %b want 1", bus.busy); end
        wait_done(cyc);
        if (cyc !== 5) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 5", cyc); end
        if (bus.r2 !== 32'h3) begin n_fail++; $display("FAIL b2b_second_r2: got %h want 3", bus.r2); end
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_exact();
        test_quantised();
        test_unsolved();
        test_saturation();
        test_boundary();
        test_control();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
